// File: rtl/aurora_rx_sync_ctrl_if.sv
// Lane-side signal bundle for the Aurora 64b/66b RX block-lock controller.
//
// Handshake: header_valid_i is a strobe with no back-pressure. header_i is
// meaningful only in a cycle where header_valid_i=1, and each such cycle
// carries exactly one new block header. The controller cannot stall the
// gearbox; it only requests a one-bit realignment with gearbox_slip_o.
//
// Signals:
//   header_i        sync header of the current gearbox block
//   header_valid_i  header_i carries a new block header this cycle
//   gearbox_slip_o  one-cycle slip request to the gearbox
//   locked_o        block lock achieved
//   fail_o          sticky: slip limit reached without lock
//   slip_cnt_o      slips since last lock or reset, saturating at 255
//   err_cnt_o       invalid headers in the current window (LOCKED only)
//   stat_o          {fail_o, locked_o, state[1:0], 4'b0}
//
// Modports: slave = the controller, master = gearbox / status consumer.
interface aurora_rx_sync_ctrl_if;
    logic [1:0] header_i;
    logic       header_valid_i;
    logic       gearbox_slip_o;
    logic       locked_o;
    logic       fail_o;
    logic [7:0] slip_cnt_o;
    logic [7:0] err_cnt_o;
    logic [7:0] stat_o;

    modport slave (
        input  header_i, header_valid_i,
        output gearbox_slip_o, locked_o, fail_o, slip_cnt_o, err_cnt_o, stat_o
    );

    modport master (
        output header_i, header_valid_i,
        input  gearbox_slip_o, locked_o, fail_o, slip_cnt_o, err_cnt_o, stat_o
    );
endinterface

// File: rtl/aurora_rx_sync_ctrl.sv
// Block-lock controller for one Aurora 64b/66b RX lane.
//
// Watches the 2-bit sync header of each gearbox block, slips the gearbox one
// bit at a time until headers line up, declares lock after a run of good
// headers, and drops lock when too many bad headers land in one window.
//
// Ports:
//   clk_rx_i  RX parallel clock (only clock)
//   rst_i     asynchronous, active-high reset
//   lane      aurora_rx_sync_ctrl_if.slave: header in, slip/lock/status out
//
// The FSM state is visible on stat_o[5:4].
module aurora_rx_sync_ctrl #(
    parameter int GOOD_HDR_LOCK = 32,
    parameter int SLIP_SETTLE   = 4,
    parameter int ERR_WINDOW    = 64,
    parameter int ERR_MAX       = 16,
    parameter int SLIP_LIMIT    = 132
) (
    input logic                   clk_rx_i,
    input logic                   rst_i,
    aurora_rx_sync_ctrl_if.slave  lane
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_SLIP   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam int GW = $clog2(GOOD_HDR_LOCK + 1);
    localparam int WW = $clog2(ERR_WINDOW + 1);
    localparam int SW = $clog2(SLIP_SETTLE + 1);

    logic [1:0]    state;
    logic [GW-1:0] good_cnt;
    logic [WW-1:0] win_cnt;
    logic [SW-1:0] settle_cnt;
    logic [7:0]    err_cnt;
    logic [7:0]    slip_cnt;
    logic [8:0]    limit_cnt;
    logic          slip_q;
    logic          locked_q;
    logic          fail_q;

    logic          hdr_ok;
    logic          hdr_bad;
    logic [GW-1:0] good_nxt;
    logic [WW-1:0] win_nxt;
    logic [SW-1:0] settle_nxt;
    logic [7:0]    err_nxt;
    logic [8:0]    limit_nxt;

    // 01 and 10 are the only legal sync headers; 00/11 mean misalignment.
    assign hdr_ok  = lane.header_valid_i && (lane.header_i[1] ^ lane.header_i[0]);
    assign hdr_bad = lane.header_valid_i && !(lane.header_i[1] ^ lane.header_i[0]);

    assign good_nxt   = good_cnt + GW'(1);
    assign win_nxt    = win_cnt + WW'(1);
    assign settle_nxt = settle_cnt + SW'(1);
    assign err_nxt    = err_cnt + {7'd0, hdr_bad};
    assign limit_nxt  = limit_cnt + 9'd1;

    always_ff @(posedge clk_rx_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_HUNT;
            good_cnt   <= '0;
            win_cnt    <= '0;
            settle_cnt <= '0;
            err_cnt    <= '0;
            slip_cnt   <= '0;
            limit_cnt  <= '0;
            slip_q     <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            slip_q <= 1'b0;
            case (state)
                ST_HUNT: begin
                    if (hdr_ok) begin
                        if (good_nxt == GW'(GOOD_HDR_LOCK)) begin
                            state     <= ST_LOCKED;
                            locked_q  <= 1'b1;
                            good_cnt  <= '0;
                            win_cnt   <= '0;
                            err_cnt   <= '0;
                            slip_cnt  <= '0;
                            limit_cnt <= '0;
                        end else begin
                            good_cnt <= good_nxt;
                        end
                    end else if (hdr_bad) begin
                        // The slip pulse and its bookkeeping share one edge so
                        // slip_cnt_o/fail_o move together with gearbox_slip_o.
                        good_cnt <= '0;
                        state    <= ST_SLIP;
                        slip_q   <= 1'b1;
                        if (slip_cnt != 8'hFF) begin
                            slip_cnt <= slip_cnt + 8'd1;
                        end
                        if (limit_nxt == 9'(SLIP_LIMIT)) begin
                            fail_q    <= 1'b1;
                            limit_cnt <= '0;
                        end else begin
                            limit_cnt <= limit_nxt;
                        end
                    end
                end
                ST_SLIP: begin
                    // Any strobe arriving during the pulse cycle is discarded.
                    state      <= ST_SETTLE;
                    settle_cnt <= '0;
                end
                ST_SETTLE: begin
                    if (lane.header_valid_i) begin
                        if (settle_nxt == SW'(SLIP_SETTLE)) begin
                            settle_cnt <= '0;
                            state      <= ST_HUNT;
                        end else begin
                            settle_cnt <= settle_nxt;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (lane.header_valid_i) begin
                        // Loss of lock wins over a window boundary on the same strobe.
                        if (err_nxt == 8'(ERR_MAX)) begin
                            state    <= ST_HUNT;
                            locked_q <= 1'b0;
                            good_cnt <= '0;
                            err_cnt  <= '0;
                            win_cnt  <= '0;
                        end else if (win_nxt == WW'(ERR_WINDOW)) begin
                            win_cnt <= '0;
                            err_cnt <= '0;
                        end else begin
                            win_cnt <= win_nxt;
                            err_cnt <= err_nxt;
                        end
                    end
                end
                default: state <= ST_HUNT;
            endcase
        end
    end

    assign lane.gearbox_slip_o = slip_q;
    assign lane.locked_o       = locked_q;
    assign lane.fail_o         = fail_q;
    assign lane.slip_cnt_o     = slip_cnt;
    // err_cnt only moves in LOCKED and is cleared on exit, so it reads 0 elsewhere.
    assign lane.err_cnt_o      = err_cnt;
    assign lane.stat_o         = {fail_q, locked_q, state, 4'b0000};

endmodule
